// File: rtl/oc_qsfp_pkg.sv
// Shared types and default timing constants for the QSFP sideband sequencer.
// Defaults are sized for a 156.25 MHz reference clock.
package oc_qsfp_pkg;

  typedef enum logic [2:0] {
    ABSENT   = 3'd0,
    DEBOUNCE = 3'd1,
    RESET    = 3'd2,
    INIT     = 3'd3,
    READY    = 3'd4
  } state_e;

  localparam int unsigned DefaultDebounceCycles  = 156_250;
  localparam int unsigned DefaultResetHoldCycles = 1_600;
  localparam int unsigned DefaultInitWaitCycles  = 312_500_000;

  function automatic int unsigned maxOf3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oc_qsfp_input_sync.sv
// Two-flop synchronizer for asynchronous sideband pins; resets to all-ones
// so active-low pins read as deasserted while in reset.
module oc_qsfp_input_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [Width-1:0] asyncIn,
  output logic [Width-1:0] syncOut
);

  logic [Width-1:0] meta;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      meta    <= '1;
      syncOut <= '1;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/oc_qsfp_sideband.sv
// Per-cage QSFP sideband sequencer: debounce ModPrsL, pulse ResetL, wait init, report status.
// Optional interrupt counter enabled by defining OC_QSFP_SIDEBAND_INT_COUNT_EN.
module oc_qsfp_sideband
  import oc_qsfp_pkg::*;
#(
  parameter int unsigned DebounceCycles  = DefaultDebounceCycles,
  parameter int unsigned ResetHoldCycles = DefaultResetHoldCycles,
  parameter int unsigned InitWaitCycles  = DefaultInitWaitCycles
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        enable,
  input  logic        softResetReq,
  input  logic        lpModeReq,
  input  logic        modPrsLIn,
  input  logic        intLIn,
  output logic        resetLOut,
  output logic        resetLTristate,
  output logic        lpModeOut,
  output logic        lpModeTristate,
  output logic        modSelLOut,
  output logic        modSelLTristate,
  output logic        present,
  output logic        ready,
  output logic        intActive,
  output state_e      state,
  output logic [15:0] intCount
);

  localparam int unsigned CounterWidth =
    $clog2(maxOf3(DebounceCycles, ResetHoldCycles, InitWaitCycles)) + 1;

  localparam logic [CounterWidth-1:0] DebounceTerm  = CounterWidth'(DebounceCycles - 1);
  localparam logic [CounterWidth-1:0] ResetHoldTerm = CounterWidth'(ResetHoldCycles - 1);
  localparam logic [CounterWidth-1:0] InitWaitTerm  = CounterWidth'(InitWaitCycles - 1);

  logic                    syncPrsL;
  logic                    syncIntL;
  logic [CounterWidth-1:0] count;
  logic [CounterWidth-1:0] countTerm;
  logic                    countDone;
  state_e                  stateNext;

  oc_qsfp_input_sync #(.Width(2)) uInputSync (
    .clock   (clock),
    .resetN  (resetN),
    .asyncIn ({modPrsLIn, intLIn}),
    .syncOut ({syncPrsL, syncIntL})
  );

  assign resetLTristate  = 1'b0;
  assign lpModeTristate  = 1'b0;
  assign modSelLTristate = 1'b0;

  always_comb begin
    countTerm = '1;
    unique case (state)
      DEBOUNCE: countTerm = DebounceTerm;
      RESET:    countTerm = ResetHoldTerm;
      INIT:     countTerm = InitWaitTerm;
      default:  countTerm = '1;
    endcase
  end

  assign countDone = (count == countTerm);

  always_comb begin
    stateNext = state;
    unique case (state)
      ABSENT:   if (!syncPrsL) stateNext = DEBOUNCE;
      DEBOUNCE: begin
        if (syncPrsL)       stateNext = ABSENT;
        else if (countDone) stateNext = RESET;
      end
      RESET: begin
        if (syncPrsL)                 stateNext = ABSENT;
        else if (countDone && enable) stateNext = INIT;
      end
      INIT: begin
        if (syncPrsL)                     stateNext = ABSENT;
        else if (softResetReq || !enable) stateNext = RESET;
        else if (countDone)               stateNext = READY;
      end
      READY: begin
        if (syncPrsL)                     stateNext = ABSENT;
        else if (softResetReq || !enable) stateNext = RESET;
      end
      default: stateNext = ABSENT;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  // The counter freezes at its terminal value so a parked RESET can still leave once enabled.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= ABSENT;
      count      <= '0;
      resetLOut  <= 1'b0;
      lpModeOut  <= 1'b1;
      modSelLOut <= 1'b1;
      present    <= 1'b0;
      ready      <= 1'b0;
      intActive  <= 1'b0;
    end else begin
      state <= stateNext;
      if (stateNext != state) begin
        count <= '0;
      end else if (!countDone && (count != '1)) begin
        count <= count + CounterWidth'(1);
      end
      resetLOut  <= (stateNext == INIT) || (stateNext == READY);
      lpModeOut  <= (stateNext == READY) ? lpModeReq : 1'b1;
      modSelLOut <= (stateNext != READY);
      present    <= (stateNext == RESET) || (stateNext == INIT) || (stateNext == READY);
      ready      <= (stateNext == READY);
      intActive  <= (stateNext == READY) && !syncIntL;
    end
  end

`ifdef OC_QSFP_SIDEBAND_INT_COUNT_EN
  logic intLPrev;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      intLPrev <= 1'b1;
      intCount <= '0;
    end else begin
      intLPrev <= syncIntL;
      if ((stateNext == ABSENT) && (state != ABSENT)) begin
        intCount <= '0;
      end else if (ready && intLPrev && !syncIntL && (intCount != '1)) begin
        intCount <= intCount + 16'd1;
      end
    end
  end
`else
  assign intCount = '0;
`endif

endmodule
